// File: rtl/wide_add_seq_if.sv
// Bundle of the request, adder-slice and result channels of the multi-precision add/sub sequencer.
// Both request and result channels transfer on a rising clk edge where valid && ready are both 1.
interface wide_add_seq_if #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
);
  // Once valid rises, the producer keeps valid and its payload unchanged
  // until the edge where ready is also 1. The consumer may raise or drop ready
  // at any time. The request transfers on in_valid/in_ready, and the result on out_valid/out_ready.
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*WORDS-1:0]   in_a;
  logic [WIDTH*WORDS-1:0]   in_b;
  logic                     in_cin;
  logic                     in_sub;

  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_cout;

  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*WORDS-1:0]   out_sum;
  logic                     out_cout;
  logic                     out_vout;
  logic                     out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub,
    input  in_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  out_valid, out_sum, out_cout, out_vout, out_zero,
    output out_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub,
    output in_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output out_valid, out_sum, out_cout, out_vout, out_zero,
    input  out_ready
  );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract sequencer: walks WIDTH*WORDS-bit operands through one external
// WIDTH-bit adder slice, LSW first, carrying between words in a register.
module wide_add_seq #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wide_add_seq_if.slave     bus,
  output logic [1:0]        dbg_state
);
  localparam int FW   = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [FW-1:0]   a_q, a_d;
  logic [FW-1:0]   b_q, b_d;
  logic [FW-1:0]   r_q, r_d;
  logic            cout_q, cout_d;
  logic            vout_q, vout_d;
  logic            zero_q, zero_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [WIDTH-1:0] cur_a, cur_b;
  logic [WIDTH-1:0] add_a_c, add_b_c;
  logic             add_cin_c;
  logic             last_word;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    cout_d      = cout_q;
    vout_d      = vout_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    add_a_c     = '0;
    add_b_c     = '0;
    add_cin_c   = 1'b0;
    cur_a       = '0;
    cur_b       = '0;

    // Word select via constant slices so idx never forms an out-of-range part-select.
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDXW'(w)) begin
        cur_a = a_q[w*WIDTH +: WIDTH];
        cur_b = b_q[w*WIDTH +: WIDTH];
      end
    end
    last_word = (idx_q == IDXW'(WORDS - 1));

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.in_a;
          b_d        = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d    = bus.in_sub ? 1'b1 : bus.in_cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        add_a_c   = cur_a;
        add_b_c   = cur_b;
        add_cin_c = carry_q;
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IDXW'(w)) r_d[w*WIDTH +: WIDTH] = bus.add_sum;
        end
        carry_d = bus.add_cout;
        if (last_word) begin
          // Lower words already hold this op's result, so r_d is the complete sum here.
          idx_d       = '0;
          cout_d      = bus.add_cout;
          vout_d      = (a_q[FW-1] == b_q[FW-1]) && (bus.add_sum[WIDTH-1] != a_q[FW-1]);
          zero_d      = (r_d == '0);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        idx_d       = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      cout_q      <= 1'b0;
      vout_q      <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      cout_q      <= cout_d;
      vout_q      <= vout_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.add_a     = add_a_c;
  assign bus.add_b     = add_b_c;
  assign bus.add_cin   = add_cin_c;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = r_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_vout  = vout_q;
  assign bus.out_zero  = zero_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq: behavioural adder slice, driver tasks, queue scoreboard and a
// monitor that checks every result handshake.
module tb_wide_add_seq;
  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int FW    = WIDTH * WORDS;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [FW+2:0] exp_q[$];

  wide_add_seq_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

  wide_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // External combinational adder slice.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_cin};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW+2:0] mk(input logic [FW-1:0] s, input logic c, input logic v, input logic z);
    return {s, c, v, z};
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic cin,
                      input logic sub, input logic [FW+2:0] exp);
    bit ok;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      // Scramble after the accept edge: the op must use only the sampled values.
      bus.in_valid = 1'b0;
      bus.in_a     = {$urandom, $urandom};
      bus.in_b     = {$urandom, $urandom};
      bus.in_cin   = 1'($urandom_range(0, 1));
      bus.in_sub   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_valid", 64'(seen), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        logic [FW+2:0] e;
        e = exp_q.pop_front();
        check("out_sum",  bus.out_sum, e[FW+2:3]);
        check("out_cout", 64'(bus.out_cout), 64'(e[2]));
        check("out_vout", 64'(bus.out_vout), 64'(e[1]));
        check("out_zero", 64'(bus.out_zero), 64'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sum",   bus.out_sum, 64'd0);
    check("rst_flags",     64'({bus.out_cout, bus.out_vout, bus.out_zero}), 64'd0);
    check("rst_add_bus",   64'({bus.add_a, bus.add_b, bus.add_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: carry from word 0 into word 1, with latency check
    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, mk(64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_valid_c%0d", k), 64'(bus.out_valid), 64'(k == 4));
    end
    check("in_ready_low_in_done", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
    check("valid_drop_after_hs", 64'(bus.out_valid), 64'd0);

    // 2: carry ripples through all words
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, mk(64'h0, 1'b1, 1'b0, 1'b1));
    // 3: signed overflow on subtract and on add
    send(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0));
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0));
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0));
    // 4: in_cin ignored on subtract
    send(64'h5, 64'h5, 1'b1, 1'b1, mk(64'h0, 1'b1, 1'b0, 1'b1));
    // add with carry-in
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0, mk(64'h0, 1'b1, 1'b0, 1'b1));
    drain();

    // 5: backpressure in DONE with a pending request
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
         mk(64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1'b0));
    wait_valid();
    fork
      send(64'h0000_0000_0001_0000, 64'h1, 1'b0, 1'b1, mk(64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 1'b0));
      begin
        for (int k = 0; k < 10; k++) begin
          @(posedge clk);
          #1;
          check("hold_out_valid", 64'(bus.out_valid), 64'd1);
          check("hold_in_ready",  64'(bus.in_ready), 64'd0);
          check("hold_out_sum",   bus.out_sum, 64'h2345_6789_ABCD_F001);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // 6: reset during the second RUN cycle
    send(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, mk(64'h0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_out_sum",   bus.out_sum, 64'd0);
    check("abort_flags",     64'({bus.out_cout, bus.out_vout, bus.out_zero}), 64'd0);
    check("abort_add_bus",   64'({bus.add_a, bus.add_b, bus.add_cin}), 64'd0);
    check("abort_in_ready",  64'(bus.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    // borrow case after the aborted op
    send(64'h0, 64'h1, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0));
    drain();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
